// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: shares one single-port ram16k between requester A (CPU) and B (DMA/screen).
// Latency: request seen in IDLE at edge N, RAM access cycle N..N+1, ack pulse cycle N+1..N+2.
// Backpressure: a requester holds req until its ack; the loser of a tie waits (round-robin).
// Ports: clk, rst_n (async, active-low); a_*/b_* request/ack/data per requester;
//        ram_in/ram_address/ram_load drive the ram16k, ram_out is its combinational read data;
//        busy is high while an access or its ack is in progress.
module ram16k_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   // Requester encoding for grant/last_grant: 0 = A, 1 = B.
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   state_t state, state_nxt;
   logic   grant, grant_nxt;
   logic   last_grant, last_grant_nxt;

   // Granted requester's access fields, muxed once for the RAM drive and capture.
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign sel_we    = (grant == SEL_B) ? b_we    : a_we;
   assign sel_addr  = (grant == SEL_B) ? b_addr  : a_addr;
   assign sel_wdata = (grant == SEL_B) ? b_wdata : a_wdata;

   // State register plus grant bookkeeping and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= SEL_A;
         last_grant <= SEL_B;   // A wins the first tie after reset
         a_rdata    <= '0;
         b_rdata    <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         // ram_out is the combinational read of the address driven this cycle.
         if (state == ACCESS && !sel_we) begin
            if (grant == SEL_B) b_rdata <= ram_out;
            else                a_rdata <= ram_out;
         end
      end
   end

   // Next-state: arbitration happens only in IDLE; ACCESS and ACK last one cycle each.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (a_req && b_req) begin
               // Tie: the side that did not win the previous tie goes now.
               grant_nxt      = ~last_grant;
               last_grant_nxt = ~last_grant;
               state_nxt      = ACCESS;
            end else if (a_req) begin
               grant_nxt = SEL_A;
               state_nxt = ACCESS;
            end else if (b_req) begin
               grant_nxt = SEL_B;
               state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state only, so ram_load cannot glitch on request changes
   // outside ACCESS and drops the instant reset forces IDLE.
   always_comb begin
      ram_in      = '0;
      ram_address = '0;
      ram_load    = 1'b0;
      a_ack       = 1'b0;
      b_ack       = 1'b0;
      busy        = 1'b0;
      case (state)
         ACCESS: begin
            ram_in      = sel_wdata;
            ram_address = sel_addr;
            ram_load    = sel_we;
            busy        = 1'b1;
         end
         ACK: begin
            a_ack = (grant == SEL_A);
            b_ack = (grant == SEL_B);
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ram16k_arbiter.md
Name: ram16k_arbiter

Overview:
- Two-port request/acknowledge arbiter that shares the single-port ram16k (16-bit data, 14-bit address) between requester A (CPU side) and requester B (DMA/screen side).
- Each granted access is a single read or write. The block owns all ram16k inputs and returns registered read data with an ack pulse.
- Fair round-robin on contention.

Parameters:
- ADDR_W, 14, address width; matches ram16k address.
- DATA_W, 16, data width; matches ram16k in/out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  requester A access request; held high until a_ack.
- a_we  input  1  A: 1 = write, 0 = read; stable while a_req.
- a_addr  input  ADDR_W  A word address; stable while a_req.
- a_wdata  input  DATA_W  A write data; stable while a_req.
- a_ack  output  1  one-cycle pulse: A access complete.
- a_rdata  output  DATA_W  A read data, valid in the a_ack cycle and held until the next A read completes.
- b_req, b_we, b_addr, b_wdata  input  1/1/ADDR_W/DATA_W  requester B, same rules as A.
- b_ack  output  1  one-cycle pulse: B access complete.
- b_rdata  output  DATA_W  B read data, same rules as a_rdata.
- ram_in  output  DATA_W  to ram16k in.
- ram_address  output  ADDR_W  to ram16k address.
- ram_load  output  1  to ram16k load.
- ram_out  input  DATA_W  from ram16k out; combinational read of ram_address.
- busy  output  1  high in ACCESS and ACK states.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=B (so A wins the first tie), grant register cleared.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0.
  - ram_load=0, ram_address=0, ram_in=0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one of a_req/b_req high: grant that requester, go to ACCESS.
  - Both high: grant the requester that is not last_grant; update last_grant to the winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - Drive ram_address and ram_in from the granted requester's addr/wdata; ram_load = granted we. ram16k writes at the closing edge.
  - At that edge: if granted we=0, capture ram_out into the granted requester's rdata register. Go to ACK.
- ACK (exactly one cycle):
  - Granted requester's ack=1; ram_load=0.
  - Next state is IDLE unconditionally.
- Latency: request seen in IDLE at edge N; ACCESS during cycle N..N+1; ack high during cycle N+1..N+2.
  - Back-to-back accesses therefore occur every 3 cycles.
  - Requester drops req at the edge closing its ack cycle. A req still high in IDLE is treated as a new request.
- RAM outputs outside ACCESS: ram_load=0, ram_address=0, ram_in=0. ram_load is decoded from state so that it is glitch-free with respect to state.
- Write ack: a_rdata/b_rdata are unchanged on a write ack.
- Request dropped mid-access (protocol violation): the access still completes and ack still pulses; no abort.
- Other requester arriving during ACCESS/ACK: waits; it is considered in the next IDLE cycle.
- Fairness: under continuous requests from both sides, grants strictly alternate A,B,A,B.
- Reset mid-operation: state returns to IDLE immediately and ram_load drops in the same instant, so no write occurs from an interrupted ACCESS. last_grant and rdata are re-initialised.
- Width rules: no arithmetic. Addresses pass through unmodified, with no wrap or bounds logic; the full 0..16383 range is legal.

Test Plan:
- Reset: rst_n=0 mid-run, with state forced into ACCESS and a write pending -> all outputs 0, ram_load=0 immediately. After release, a write to addr 5 does not show the pre-reset data.
- A write then read: a_req, we=1, addr=0x1234, wdata=0xBEEF -> ram_load high for exactly one cycle, a_ack one cycle later. Then A read of addr 0x1234 -> a_ack with a_rdata=0xBEEF, 3 cycles after request.
- B-only read: b_req, we=0, addr=0x3FFF (pre-written 0x0001) -> b_ack, b_rdata=0x0001. a_ack stays 0 and a_rdata is unchanged.
- Simultaneous first contention after reset: a_req and b_req both high, both writes (A: addr 10 ← 0x00AA; B: addr 11 ← 0x00BB) -> A granted first, B next. Both values read back correctly.
- Continuous contention: both requests held for 12 cycles -> ack order A,B,A,B, one ack every 3 cycles, never both acks in the same cycle.
- Protocol violation: a_req dropped during ACCESS -> a_ack still pulses once, and the RAM write still occurs.
